// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB first over WIDTH
// cycles, threads the carry between cycles and assembles the result word and flags.
module alu_serial_seq #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [4:0]       AluCtl,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             CarryOut,
    output logic             IllegalOp,
    output logic             SliceA,
    output logic             SliceB,
    output logic             SliceAInvert,
    output logic             SliceBInvert,
    output logic             SliceCarryIn,
    output logic             SliceLess,
    output logic [2:0]       SliceOperation,
    input  logic             SliceResult,
    input  logic             SliceCarryOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             ainv_q, binv_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] k_q;
    logic             carry_q;
    logic             set_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, ovf_q, cout_q, illegal_q;

    logic             illegal;
    logic             arith;
    logic             last;
    logic             ovf_msb;

    assign illegal = (op_q > OP_XOR);
    assign arith   = (op_q == OP_ADD) || (op_q == OP_SLT);
    assign last    = (k_q == K_LAST);
    // Signed overflow of the MSB slice: carry into it differs from carry out of it.
    assign ovf_msb = carry_q ^ SliceCarryOut;

    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = cout_q;
    assign IllegalOp = illegal_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        result_d       = result_q;
        Ready          = 1'b0;
        Done           = 1'b0;
        SliceA         = 1'b0;
        SliceB         = 1'b0;
        SliceAInvert   = 1'b0;
        SliceBInvert   = 1'b0;
        SliceCarryIn   = 1'b0;
        SliceLess      = 1'b0;
        SliceOperation = OP_AND;

        case (state_q)
            S_IDLE: begin
                Ready = 1'b1;
                if (Start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                SliceA       = a_q[0];
                SliceB       = b_q[0];
                SliceAInvert = ainv_q;
                SliceBInvert = binv_q;
                SliceCarryIn = carry_q;
                if (illegal) begin
                    SliceOperation = OP_AND;
                end else if (op_q == OP_SLT) begin
                    SliceOperation = OP_ADD;
                end else begin
                    SliceOperation = op_q;
                end
                result_d[k_q] = SliceResult & ~illegal;
                if (last) begin
                    state_d = (op_q == OP_SLT) ? S_FIX : S_DONE;
                end
            end

            // Operands have rotated a full turn, so bit 0 is back at position 0.
            S_FIX: begin
                SliceA         = a_q[0];
                SliceB         = b_q[0];
                SliceAInvert   = ainv_q;
                SliceBInvert   = binv_q;
                SliceCarryIn   = binv_q;
                SliceLess      = set_q;
                SliceOperation = OP_SLT;
                result_d       = '0;
                result_d[0]    = SliceResult;
                state_d        = S_DONE;
            end

            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: all state, including the operand shift registers, is reset so that a reset
    // mid-operation leaves no stale bits visible on the slice interface or Result.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ainv_q    <= 1'b0;
            binv_q    <= 1'b0;
            op_q      <= OP_AND;
            k_q       <= '0;
            carry_q   <= 1'b0;
            set_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        a_q       <= OpA;
                        b_q       <= OpB;
                        ainv_q    <= AluCtl[4];
                        binv_q    <= AluCtl[3];
                        op_q      <= AluCtl[2:0];
                        k_q       <= '0;
                        carry_q   <= AluCtl[3];
                        ovf_q     <= 1'b0;
                        cout_q    <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end

                S_RUN: begin
                    a_q      <= {a_q[0], a_q[WIDTH-1:1]};
                    b_q      <= {b_q[0], b_q[WIDTH-1:1]};
                    carry_q  <= SliceCarryOut;
                    k_q      <= k_q + 1'b1;
                    result_q <= result_d;
                    if (last) begin
                        ovf_q     <= arith & ovf_msb;
                        cout_q    <= SliceCarryOut & ~illegal;
                        set_q     <= SliceResult ^ ovf_msb;
                        illegal_q <= illegal;
                        if (op_q != OP_SLT) begin
                            zero_q <= (result_d == '0);
                        end
                    end
                end

                S_FIX: begin
                    result_q <= result_d;
                    zero_q   <= (result_d == '0);
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed cases plus random operations
// compared against a word-level arithmetic model of the serial ALU.
module tb_alu_serial_seq;

    localparam int WIDTH = 24;
    localparam int CNT_W = 5;

    logic             Clock;
    logic             Reset;
    logic             Start;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [4:0]       AluCtl;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;
    logic             CarryOut;
    logic             IllegalOp;
    logic             SliceA;
    logic             SliceB;
    logic             SliceAInvert;
    logic             SliceBInvert;
    logic             SliceCarryIn;
    logic             SliceLess;
    logic [2:0]       SliceOperation;
    logic             SliceResult;
    logic             SliceCarryOut;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             cout;
        logic             illegal;
        int               latency;
    } exp_t;

    alu_serial_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .OpA            (OpA),
        .OpB            (OpB),
        .AluCtl         (AluCtl),
        .Ready          (Ready),
        .Done           (Done),
        .Result         (Result),
        .Zero           (Zero),
        .Overflow       (Overflow),
        .CarryOut       (CarryOut),
        .IllegalOp      (IllegalOp),
        .SliceA         (SliceA),
        .SliceB         (SliceB),
        .SliceAInvert   (SliceAInvert),
        .SliceBInvert   (SliceBInvert),
        .SliceCarryIn   (SliceCarryIn),
        .SliceLess      (SliceLess),
        .SliceOperation (SliceOperation),
        .SliceResult    (SliceResult),
        .SliceCarryOut  (SliceCarryOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // External 1-bit ALU slice the sequencer drives.
    logic sa, sb;
    always_comb begin
        sa            = SliceA ^ SliceAInvert;
        sb            = SliceB ^ SliceBInvert;
        SliceCarryOut = (sa & sb) | (sa & SliceCarryIn) | (sb & SliceCarryIn);
        case (SliceOperation)
            3'b000:  SliceResult = sa & sb;
            3'b001:  SliceResult = sa | sb;
            3'b010:  SliceResult = sa ^ sb ^ SliceCarryIn;
            3'b011:  SliceResult = SliceLess;
            3'b100:  SliceResult = sa ^ sb;
            default: SliceResult = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: two's-complement arithmetic on the (optionally inverted) operands.
    function automatic exp_t model(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                                   input logic [4:0] ctl);
        exp_t             e;
        logic [WIDTH-1:0] a, b, r;
        logic [WIDTH:0]   s;
        logic             ovf_raw;
        int               op;
        op = int'(ctl[2:0]);
        a  = ctl[4] ? ~a_in : a_in;
        b  = ctl[3] ? ~b_in : b_in;
        s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ctl[3]};
        ovf_raw = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        case (op)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = s[WIDTH-1:0];
            3:       r = (s[WIDTH-1] ^ ovf_raw) ? WIDTH'(1) : '0;
            4:       r = a ^ b;
            default: r = '0;
        endcase
        e.result  = r;
        e.zero    = (r == '0);
        e.ovf     = (op == 2 || op == 3) ? ovf_raw : 1'b0;
        e.cout    = (op <= 4) ? s[WIDTH] : 1'b0;
        e.illegal = (op > 4);
        e.latency = (op == 3) ? WIDTH + 2 : WIDTH + 1;
        return e;
    endfunction

    function automatic logic [8:0] slice_bus();
        return {SliceA, SliceB, SliceAInvert, SliceBInvert, SliceCarryIn, SliceLess, SliceOperation};
    endfunction

    task automatic check_reset_state(input string name);
        check({name, "/ready"},   32'(Ready), 32'd1);
        check({name, "/done"},    32'(Done), 32'd0);
        check({name, "/result"},  32'(Result), 32'd0);
        check({name, "/zero"},    32'(Zero), 32'd1);
        check({name, "/flags"},   32'({Overflow, CarryOut, IllegalOp}), 32'd0);
        check({name, "/slice"},   32'(slice_bus()), 32'd0);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [4:0] ctl, input bit hammer, input string name);
        exp_t       e;
        int         lat;
        int         ready_low;
        int         exp_sop;
        bit         seen;
        e = model(a, b, ctl);
        exp_sop = (ctl[2:0] > 3'd4) ? 0 : (ctl[2:0] == 3'd3) ? 2 : int'(ctl[2:0]);
        @(negedge Clock);
        check({name, "/ready_before"}, 32'(Ready), 32'd1);
        OpA    = a;
        OpB    = b;
        AluCtl = ctl;
        Start  = 1'b1;
        @(posedge Clock);
        #1;
        if (!hammer) Start = 1'b0;
        OpA    = WIDTH'($urandom);
        OpB    = WIDTH'($urandom);
        AluCtl = 5'($urandom);
        lat       = 0;
        ready_low = 0;
        seen      = 1'b0;
        for (int c = 1; c <= WIDTH + 10; c++) begin
            @(negedge Clock);
            if (!Ready) ready_low++;
            if (c == 1) begin
                check({name, "/slice_bit0"}, 32'({SliceA, SliceB, SliceAInvert, SliceBInvert, SliceCarryIn, SliceLess}),
                      32'({a[0], b[0], ctl[4], ctl[3], ctl[3], 1'b0}));
                check({name, "/slice_op"}, 32'(SliceOperation), 32'(exp_sop));
            end
            if (Done) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
        end
        Start = 1'b0;
        if (!seen) begin
            check({name, "/done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "/latency"},   32'(lat), 32'(e.latency));
            check({name, "/ready_low"}, 32'(ready_low), 32'(e.latency));
            check({name, "/result"},    32'(Result), 32'(e.result));
            check({name, "/zero"},      32'(Zero), 32'(e.zero));
            check({name, "/overflow"},  32'(Overflow), 32'(e.ovf));
            check({name, "/carryout"},  32'(CarryOut), 32'(e.cout));
            check({name, "/illegal"},   32'(IllegalOp), 32'(e.illegal));
            @(negedge Clock);
            check({name, "/done_pulse"}, 32'({Done, Ready}), 32'b01);
            check({name, "/idle_slice"}, 32'(slice_bus()), 32'd0);
            check({name, "/result_hold"}, 32'({Result, Zero, Overflow, CarryOut, IllegalOp}),
                  32'({e.result, e.zero, e.ovf, e.cout, e.illegal}));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic [4:0]       rctl;
        logic [WIDTH-1:0] corners [4];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = 24'h800000;
        corners[3] = 24'h7FFFFF;

        Reset  = 1'b0;
        Start  = 1'b0;
        OpA    = '0;
        OpB    = '0;
        AluCtl = '0;
        repeat (3) @(posedge Clock);
        #1;
        check_reset_state("reset");
        @(negedge Clock);
        Reset = 1'b1;

        run_op(24'h7FFFFF, 24'h000001, 5'b00010, 1'b0, "add_ovf");
        run_op(24'h000005, 24'h000005, 5'b01010, 1'b0, "sub_zero");
        run_op(24'hFFFFFF, 24'h000001, 5'b01011, 1'b0, "slt_neg");
        run_op(24'h7FFFFF, 24'h800000, 5'b01011, 1'b0, "slt_ovf");
        run_op(24'h0F0F0F, 24'h00FF00, 5'b11000, 1'b0, "nor");
        run_op(24'h0F0F0F, 24'h00FF00, 5'b00100, 1'b0, "xor");
        run_op(24'h0F0F0F, 24'h00FF00, 5'b00001, 1'b0, "or");
        run_op(24'h123456, 24'h654321, 5'b00010, 1'b1, "hammer");
        run_op(24'hABCDEF, 24'hFFFFFF, 5'b00111, 1'b0, "illegal");

        // Reset while RUN is at bit 10, then a fresh ADD.
        @(negedge Clock);
        OpA    = 24'h123456;
        OpB    = 24'h0F0F0F;
        AluCtl = 5'b00010;
        Start  = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (11) @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        check_reset_state("mid_reset");
        @(negedge Clock);
        Reset = 1'b1;
        run_op(24'h123456, 24'h0F0F0F, 5'b00010, 1'b0, "add_after_reset");

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : WIDTH'($urandom);
            rctl[4:3] = 2'($urandom);
            rctl[2:0] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            run_op(ra, rb, rctl, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
